key_mode_fsm: RTL and testbench

KEY_MODE_FSM -- requirements
Module: key_mode_fsm

---
 rtl/key_mode_if.sv | 35 +++
 rtl/key_mode_fsm.sv | 146 ++++++++++++++
 tb/tb_key_mode_fsm.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/key_mode_if.sv
// ============================================================================
//  Module   : key_mode_if
//  Brief    : Key-pulse inputs and mode/value outputs of the key mode selector.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface key_mode_if;
    logic       key_short;
    logic       key_long;
    logic [2:0] mode_sel;
    logic [3:0] cur_val;
    logic       editing;
    logic       apply;

    modport master (
        output key_short,
        output key_long,
        input  mode_sel,
        input  cur_val,
        input  editing,
        input  apply
    );

    modport slave (
        input  key_short,
        input  key_long,
        output mode_sel,
        output cur_val,
        output editing,
        output apply
    );
endinterface

`default_nettype wire

// File: rtl/key_mode_fsm.sv
// ============================================================================
//  Module   : key_mode_fsm
//  Brief    : Two-key mode browser / value editor with per-mode committed slots
//             and an idle timeout that abandons an edit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_mode_fsm #(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int NUM_MODES  = 4,
    parameter int VAL_MAX    = 15,
    parameter int TIMEOUT_MS = 5000
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    key_mode_if.slave  bus
);

    localparam logic [31:0] c_cnt_to    = 32'((CLK_FREQ / 1000) * TIMEOUT_MS);
    localparam logic [31:0] c_cnt_last  = c_cnt_to - 32'd1;
    localparam logic [2:0]  c_mode_last = 3'(NUM_MODES - 1);
    localparam logic [3:0]  c_val_max   = 4'(VAL_MAX);

    localparam logic [0:0]  c_browse    = 1'b0;
    localparam logic [0:0]  c_edit      = 1'b1;

    logic [0:0]  r_state;
    logic [2:0]  r_mode_sel;
    logic [3:0]  r_edit_val;
    logic [31:0] r_cnt;
    logic [3:0]  r_cur_val;
    logic        r_editing;
    logic        r_apply;

    logic [0:0]  w_state_nxt;
    logic [2:0]  w_mode_nxt;
    logic [3:0]  w_edit_nxt;
    logic [31:0] w_cnt_nxt;
    logic        w_commit;

    logic [3:0]  w_cur_nxt;
    logic        w_editing_nxt;
    logic        w_apply_nxt;

    // Eight slot views always exist so a 3-bit mode index never runs off the
    // array; slots beyond NUM_MODES read as zero and are never written.
    logic [3:0]  w_slot [0:7];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_slot
            if (gi < NUM_MODES) begin : g_live
                logic [3:0] r_val;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_val <= 4'd0;
                    end else if (w_commit && (r_mode_sel == 3'(gi))) begin
                        r_val <= r_edit_val;
                    end
                end
                assign w_slot[gi] = r_val;
            end else begin : g_tie
                assign w_slot[gi] = 4'd0;
            end
        end
    endgenerate

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_browse;
            r_mode_sel <= 3'd0;
            r_edit_val <= 4'd0;
            r_cnt      <= 32'd0;
            r_cur_val  <= 4'd0;
            r_editing  <= 1'b0;
            r_apply    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mode_sel <= w_mode_nxt;
            r_edit_val <= w_edit_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cur_val  <= w_cur_nxt;
            r_editing  <= w_editing_nxt;
            r_apply    <= w_apply_nxt;
        end
    end

    // Next state; key_long outranks key_short, and any key outranks timeout
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode_sel;
        w_edit_nxt  = r_edit_val;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            c_browse: begin
                if (bus.key_long) begin
                    w_state_nxt = c_edit;
                    w_edit_nxt  = w_slot[r_mode_sel];
                    w_cnt_nxt   = 32'd0;
                end else if (bus.key_short) begin
                    w_mode_nxt = (r_mode_sel >= c_mode_last) ? 3'd0 : r_mode_sel + 3'd1;
                end
            end
            c_edit: begin
                if (bus.key_long) begin
                    w_state_nxt = c_browse;
                    w_commit    = 1'b1;
                end else if (bus.key_short) begin
                    w_edit_nxt = (r_edit_val >= c_val_max) ? 4'd0 : r_edit_val + 4'd1;
                    w_cnt_nxt  = 32'd0;
                end else if (r_cnt >= c_cnt_last) begin
                    w_state_nxt = c_browse;
                end else if (r_cnt != 32'hFFFF_FFFF) begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            default: begin
                w_state_nxt = c_browse;
            end
        endcase
    end

    // Next output values, registered above so every output lags its pulse by one edge
    always_comb begin
        w_editing_nxt = (w_state_nxt == c_edit);
        w_apply_nxt   = w_commit;
        if (w_editing_nxt) begin
            w_cur_nxt = w_edit_nxt;
        end else if (w_commit) begin
            w_cur_nxt = r_edit_val;
        end else begin
            w_cur_nxt = w_slot[w_mode_nxt];
        end
    end

    assign bus.mode_sel = r_mode_sel;
    assign bus.cur_val  = r_cur_val;
    assign bus.editing  = r_editing;
    assign bus.apply    = r_apply;

endmodule

`default_nettype wire

// File: tb/tb_key_mode_fsm.sv
// ============================================================================
//  Module   : tb_key_mode_fsm
//  Brief    : Directed scoreboard bench for key_mode_fsm (CNT_TO = 10).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_mode_fsm;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    key_mode_if u_if ();

    key_mode_fsm #(
        .CLK_FREQ   (1000),
        .NUM_MODES  (4),
        .VAL_MAX    (15),
        .TIMEOUT_MS (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    typedef struct {
        logic [2:0] m;
        logic [3:0] v;
        logic       e;
        logic       a;
        int         id;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_id = 0;

    task automatic chk(input string name, input int id, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, id, got, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [2:0] m, input logic [3:0] v,
                           input logic e, input logic a);
        chk({name, ".mode_sel"}, -1, 8'(u_if.mode_sel), 8'(m));
        chk({name, ".cur_val"},  -1, 8'(u_if.cur_val),  8'(v));
        chk({name, ".editing"},  -1, 8'(u_if.editing),  8'(e));
        chk({name, ".apply"},    -1, 8'(u_if.apply),    8'(a));
    endtask

    // Drive one cycle of key inputs and queue the outputs expected after its edge
    task automatic step(input logic ks, input logic kl, input logic [2:0] m,
                        input logic [3:0] v, input logic e, input logic a);
        exp_t x;
        @(negedge clk);
        u_if.key_short = ks;
        u_if.key_long  = kl;
        x.m  = m;
        x.v  = v;
        x.e  = e;
        x.a  = a;
        x.id = step_id;
        step_id++;
        q.push_back(x);
    endtask

    task automatic idle(input int n, input logic [2:0] m, input logic [3:0] v,
                        input logic e, input logic a);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, m, v, e, a);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("mode_sel", x.id, 8'(u_if.mode_sel), 8'(x.m));
                chk("cur_val",  x.id, 8'(u_if.cur_val),  8'(x.v));
                chk("editing",  x.id, 8'(u_if.editing),  8'(x.e));
                chk("apply",    x.id, 8'(u_if.apply),    8'(x.a));
            end
        end
    end

    initial begin : watchdog
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : stimulus
        u_if.key_short = 1'b0;
        u_if.key_long  = 1'b0;
        rst_n          = 1'b0;
        repeat (3) @(negedge clk);
        chk_all("reset", 3'd0, 4'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Mode wrap
        step(1, 0, 3'd1, 4'd0, 0, 0);
        step(1, 0, 3'd2, 4'd0, 0, 0);
        step(1, 0, 3'd3, 4'd0, 0, 0);
        step(1, 0, 3'd0, 4'd0, 0, 0);
        step(1, 0, 3'd1, 4'd0, 0, 0);

        // Edit and commit mode 1 to 3, then browse back round to it
        step(0, 1, 3'd1, 4'd0, 1, 0);
        step(1, 0, 3'd1, 4'd1, 1, 0);
        step(1, 0, 3'd1, 4'd2, 1, 0);
        step(1, 0, 3'd1, 4'd3, 1, 0);
        step(0, 1, 3'd1, 4'd3, 0, 1);
        idle(1, 3'd1, 4'd3, 0, 0);
        step(1, 0, 3'd2, 4'd0, 0, 0);
        step(1, 0, 3'd3, 4'd0, 0, 0);
        step(1, 0, 3'd0, 4'd0, 0, 0);
        step(1, 0, 3'd1, 4'd3, 0, 0);

        // Value wrap in mode 2: 17 increments from 0 land on 1
        step(1, 0, 3'd2, 4'd0, 0, 0);
        step(0, 1, 3'd2, 4'd0, 1, 0);
        for (int i = 1; i <= 17; i++) step(1, 0, 3'd2, 4'(i % 16), 1, 0);
        step(0, 1, 3'd2, 4'd1, 0, 1);

        // Plain timeout: edit discarded after 10 idle cycles
        step(0, 1, 3'd2, 4'd1, 1, 0);
        step(1, 0, 3'd2, 4'd2, 1, 0);
        step(1, 0, 3'd2, 4'd3, 1, 0);
        idle(9, 3'd2, 4'd3, 1, 0);
        idle(2, 3'd2, 4'd1, 0, 0);

        // key_short at idle cycle 9 restarts the count
        step(0, 1, 3'd2, 4'd1, 1, 0);
        step(1, 0, 3'd2, 4'd2, 1, 0);
        step(1, 0, 3'd2, 4'd3, 1, 0);
        idle(8, 3'd2, 4'd3, 1, 0);
        step(1, 0, 3'd2, 4'd4, 1, 0);
        idle(9, 3'd2, 4'd4, 1, 0);
        idle(1, 3'd2, 4'd1, 0, 0);

        // Key pulse in the cycle the timeout would fire wins
        step(0, 1, 3'd2, 4'd1, 1, 0);
        idle(9, 3'd2, 4'd1, 1, 0);
        step(1, 0, 3'd2, 4'd2, 1, 0);
        idle(1, 3'd2, 4'd2, 1, 0);
        step(0, 1, 3'd2, 4'd2, 0, 1);

        // Simultaneous pulses: long wins in both states
        step(1, 1, 3'd2, 4'd2, 1, 0);
        step(1, 0, 3'd2, 4'd3, 1, 0);
        step(1, 1, 3'd2, 4'd3, 0, 1);
        idle(1, 3'd2, 4'd3, 0, 0);

        // Reset mid-EDIT with edit_val = 5
        step(0, 1, 3'd2, 4'd3, 1, 0);
        step(1, 0, 3'd2, 4'd4, 1, 0);
        step(1, 0, 3'd2, 4'd5, 1, 0);
        @(negedge clk);
        u_if.key_short = 1'b0;
        u_if.key_long  = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("rst_mid", 3'd0, 4'd0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("rst_hold.apply",   k, 8'(u_if.apply),   8'd0);
            chk("rst_hold.editing", k, 8'(u_if.editing), 8'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(1, 3'd0, 4'd0, 0, 0);
        step(1, 0, 3'd1, 4'd0, 0, 0);
        step(1, 0, 3'd2, 4'd0, 0, 0);
        step(1, 0, 3'd3, 4'd0, 0, 0);
        step(1, 0, 3'd0, 4'd0, 0, 0);

        @(negedge clk);
        u_if.key_short = 1'b0;
        u_if.key_long  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", -1, 8'(q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
